pipeline_if_fetch: RTL
======================

# pipeline_if_fetch

Instruction-fetch stage that produces the IF-side inputs of the IF/ID pipeline register: instruction word, fetch PC and PC+4. Owns the program counter and a single-outstanding request/response port to instruction memory. Honours the stall and branch/jump redirects from the hazard/EX logic. Presents the instruction as a nop whenever no valid instruction is held.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RSTN  in  1  reset, asynchronous, active-low
- EnableF  in  1  1 = downstream IF/ID register captures this cycle; 0 = stall
- RedirectF  in  1  one-cycle pulse: branch/jump taken
- RedirectPC  in  32  redirect target; bits [1:0] ignored, treated as 00
- IMemReqValid  out  1  fetch request valid
- IMemReqReady  in  1  memory accepts the request
- IMemAddr  out  32  fetch address, word aligned
- IMemRspValid  in  1  response data valid; at most one per accepted request
- IMemRspData  in  32  instruction word
- RD  out  32  instruction to IF/ID; 32'h0000_0000 (nop) when InstrValidF = 0
- PCF  out  32  PC of the held instruction
- PCPlus4F  out  32  PCF + 4, modulo 2^32
- InstrValidF  out  1  RD/PCF hold a valid fetched instruction

## Operation
- Registers: PC[31:0], state, InstrBuf[31:0], Kill flag.
- States: REQ (request driven), WAIT (accepted, awaiting response), HOLD (instruction buffered, awaiting EnableF).
- IMemReqValid = (state == REQ); IMemAddr = PC; PCF = PC; InstrValidF = (state == HOLD).
- REQ: on IMemReqValid & IMemReqReady, go to WAIT. Without ready, stay in REQ.
- WAIT: on IMemRspValid with Kill = 0, capture InstrBuf and go to HOLD. With Kill = 1, discard the data, clear Kill and go to REQ.
- HOLD: on EnableF = 1, set PC <= PC + 4 and go to REQ. On EnableF = 0, hold everything.
- Redirect handling. RedirectF always sets PC <= {RedirectPC[31:2], 2'b00}, and always takes priority over EnableF.
  - REQ, no ready: stay in REQ. The address may change while unaccepted; the memory protocol permits this.
  - REQ, same cycle as ready: go to WAIT with Kill <= 1, because the old address was accepted.
  - WAIT: set Kill <= 1. If IMemRspValid arrives in the same cycle, discard it, clear Kill and go to REQ.
  - HOLD: drop the buffered instruction and go to REQ.
- Only one request is ever outstanding. A new request is never issued before the prior response has been consumed.
- PC + 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.

## Timing
- Reset (RSTN = 0, async):
  - PC = RESET_PC, state = REQ, Kill = 0, InstrBuf = 0.
  - Outputs: IMemReqValid = 1, IMemAddr = RESET_PC, RD = 0, PCF = RESET_PC, PCPlus4F = RESET_PC + 4, InstrValidF = 0.
- Reset asserted mid-transaction abandons it. The memory must drop any in-flight response across reset.
- Best-case throughput with zero-wait memory (ready high, response one cycle after acceptance): one instruction per 3 cycles (REQ, WAIT, HOLD).
- Response data reaches RD in the cycle after IMemRspValid.
- After a redirect, the first request to the target:
  - from REQ or HOLD: the next cycle;
  - from WAIT: the cycle after the killed response returns.

## Structure
- Shared package:
  - fetch state enum (REQ/WAIT/HOLD);
  - NOP_INSTR = 32'h0000_0000;
  - PC_INC = 32'd4;
  - default RESET_PC.
- Single module; no sub-module needed. The PC incrementer and output muxes stay inline.

## Test plan
- Reset release with RESET_PC = 0x00400000, ready = 1, 1-cycle memory returning 0x20080005 -> IMemAddr = 0x00400000. RD = 0x20080005, PCF = 0x00400000, PCPlus4F = 0x00400004, InstrValidF = 1 two cycles after reset release. Next IMemAddr = 0x00400004.
- Stall: hold EnableF = 0 for 4 cycles in HOLD -> RD, PCF and InstrValidF unchanged and IMemReqValid = 0. Release -> next request at PCF + 4.
- Redirect in WAIT to 0x00400100 -> the stale response is discarded (InstrValidF stays 0). The next request has IMemAddr = 0x00400100.
- Redirect and EnableF together in HOLD, target 0x00400203 -> PC = 0x00400200 and InstrValidF = 0 next cycle; no PC + 4 advance occurs.
- Wrap-around: PC = 0xFFFFFFFC -> PCPlus4F = 0x00000000 and the next fetch address is 0x00000000.
- Async reset asserted in WAIT mid-stall -> outputs take their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pipeline_if_fetch_pkg.sv
// pipeline_if_fetch_pkg: shared types and constants for the instruction-fetch stage
//   fetch_state_t    - fetch FSM states (REQ / WAIT / HOLD)
//   NOP_INSTR        - instruction presented when nothing valid is held
//   PC_INC           - sequential PC increment
//   DEFAULT_RESET_PC - default PC loaded on reset
package pipeline_if_fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pipeline_if_fetch.sv
// pipeline_if_fetch: IF stage owning the PC and a single-outstanding imem request/response port
//   CLK, RSTN                 - clock, async active-low reset
//   EnableF                   - IF/ID captures this cycle (0 = stall)
//   RedirectF, RedirectPC     - taken branch/jump pulse and its target
//   IMemReqValid/Ready, IMemAddr  - fetch request channel
//   IMemRspValid, IMemRspData     - fetch response channel
//   RD, PCF, PCPlus4F, InstrValidF - IF-side inputs of the IF/ID register
module pipeline_if_fetch
    import pipeline_if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        EnableF,
    input  logic        RedirectF,
    input  logic [31:0] RedirectPC,
    output logic        IMemReqValid,
    input  logic        IMemReqReady,
    output logic [31:0] IMemAddr,
    input  logic        IMemRspValid,
    input  logic [31:0] IMemRspData,
    output logic [31:0] RD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  instr_buf, instr_buf_n;
    logic         kill, kill_n;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= REQ;
            pc        <= RESET_PC;
            instr_buf <= NOP_INSTR;
            kill      <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            instr_buf <= instr_buf_n;
            kill      <= kill_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        instr_buf_n = instr_buf;
        kill_n      = kill;
        case (state)
            // A redirect coinciding with acceptance leaves the old address in flight.
            REQ: if (IMemReqReady) begin
                state_n = WAIT;
                kill_n  = RedirectF;
            end
            // A killed response is dropped; the redirect target is requested afterwards.
            WAIT: if (IMemRspValid) begin
                if (kill || RedirectF) begin
                    state_n = REQ;
                    kill_n  = 1'b0;
                end else begin
                    state_n     = HOLD;
                    instr_buf_n = IMemRspData;
                end
            end else if (RedirectF) begin
                kill_n = 1'b1;
            end
            HOLD: if (RedirectF || EnableF) state_n = REQ;
            default: state_n = REQ;
        endcase
        if (RedirectF)
            pc_n = RedirectPC & ~32'd3;
        else if (state == HOLD && EnableF)
            pc_n = pc + PC_INC;
    end

    assign IMemReqValid = (state == REQ);
    assign IMemAddr     = pc;
    assign PCF          = pc;
    assign PCPlus4F     = pc + PC_INC;
    assign InstrValidF  = (state == HOLD);
    assign RD           = InstrValidF ? instr_buf : NOP_INSTR;

endmodule
